weight_fetch_ctrl: RTL and testbench

Sequences reads of the synaptic weight RAM for one timestep frame. The block accepts a stream of input-spike indices, issues one RAM row read per spike, and streams the returned P-lane weight rows to the neuron-update datapath over a valid/ready interface. It sits between the spike event queue and the weight RAM (1-cycle registered read, read enable ren) and provides credit-based backpressure plus frame start/done sequencing.

---
 rtl/weight_fetch_ctrl.sv | 177 +++++++++++++++++
 tb/tb_weight_fetch_ctrl.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/weight_fetch_ctrl.sv
// Weight-RAM fetch sequencer: one row read per accepted spike, rows returned in order over valid/ready.
// Optional build macro WFC_BASE_EN adds a per-frame layer_base offset applied to the RAM address.
//
// state | meaning
// IDLE  | waiting for start
// RUN   | accepting spikes, issuing RAM reads
// DRAIN | last spike seen, waiting for in-flight rows to be delivered
// DONE  | single-cycle completion pulse
module weight_fetch_ctrl #(
   parameter int DEEPTH  = 512,
   parameter int ADDRWID = $clog2(DEEPTH),
   parameter int P       = 64,
   parameter int WIDTH   = 8*P,
   parameter int FDEPTH  = 4
) (
   input  logic               clk,
   input  logic               rst_n,
`ifdef WFC_BASE_EN
   input  logic [ADDRWID-1:0] layer_base,
`endif
   input  logic               start,
   output logic               busy,
   output logic               done,
   input  logic               spike_valid,
   output logic               spike_ready,
   input  logic [ADDRWID-1:0] spike_idx,
   input  logic               spike_last,
   output logic               ram_ren,
   output logic [ADDRWID-1:0] ram_raddr,
   input  logic [WIDTH-1:0]   ram_rdata,
   output logic               wout_valid,
   input  logic               wout_ready,
   output logic [WIDTH-1:0]   wout_data,
   output logic               wout_last,
   output logic [15:0]        fetch_cnt,
   output logic               err_oor
);

   localparam int FAW = $clog2(FDEPTH);
   localparam int OW  = $clog2(FDEPTH + 1);
   localparam logic [ADDRWID:0] DEPTH_W = (ADDRWID+1)'(DEEPTH);

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

   state_t             state, state_nxt;
   logic [OW-1:0]      outstanding;
   logic [FAW-1:0]     wr_ptr, rd_ptr;
   logic [FAW:0]       fifo_cnt;
   logic [WIDTH-1:0]   fifo_data [FDEPTH];
   logic               fifo_last [FDEPTH];
   logic               rd_pend, rd_pend_last;
   logic               start_acc, spike_acc, spike_oor, spike_rd, pop, fifo_empty;
   logic [ADDRWID-1:0] row_addr;

   assign start_acc  = (state == IDLE) && start;
   assign spike_acc  = spike_valid && spike_ready;
   assign spike_oor  = {1'b0, spike_idx} >= DEPTH_W;
   assign spike_rd   = spike_acc && !spike_oor;
   assign fifo_empty = (fifo_cnt == '0);
   assign pop        = wout_valid && wout_ready;

`ifdef WFC_BASE_EN
   logic [ADDRWID-1:0] base_q;
   logic [ADDRWID:0]   sum0, sum1, sum2;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         base_q <= '0;
      end else if (start_acc) begin
         base_q <= layer_base;
      end
   end

   // idx < DEEPTH and base < 2*DEEPTH, so two conditional subtracts give the modulo
   always_comb begin
      sum0 = {1'b0, spike_idx} + {1'b0, base_q};
      sum1 = (sum0 >= DEPTH_W) ? sum0 - DEPTH_W : sum0;
      sum2 = (sum1 >= DEPTH_W) ? sum1 - DEPTH_W : sum1;
   end

   assign row_addr = sum2[ADDRWID-1:0];
`else
   assign row_addr = spike_idx;
`endif

   assign ram_ren   = spike_rd;
   assign ram_raddr = spike_rd ? row_addr : '0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt   = state;
      busy        = 1'b1;
      done        = 1'b0;
      spike_ready = 1'b0;
      case (state)
         IDLE: begin
            busy = 1'b0;
            if (start) state_nxt = RUN;
         end
         RUN: begin
            spike_ready = (outstanding < OW'(FDEPTH));
            if (spike_valid && spike_ready && spike_last) state_nxt = DRAIN;
         end
         DRAIN: begin
            if ((outstanding == '0) && fifo_empty) state_nxt = DONE;
         end
         DONE: begin
            done      = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         outstanding  <= '0;
         rd_pend      <= 1'b0;
         rd_pend_last <= 1'b0;
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         fifo_cnt     <= '0;
         fetch_cnt    <= '0;
         err_oor      <= 1'b0;
      end else begin
         rd_pend      <= spike_rd;
         rd_pend_last <= spike_rd && spike_last;

         case ({spike_rd, pop})
            2'b10:   outstanding <= outstanding + 1'b1;
            2'b01:   outstanding <= outstanding - 1'b1;
            default: outstanding <= outstanding;
         endcase

         if (rd_pend) wr_ptr <= wr_ptr + 1'b1;
         if (pop)     rd_ptr <= rd_ptr + 1'b1;

         case ({rd_pend, pop})
            2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
            2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
            default: fifo_cnt <= fifo_cnt;
         endcase

         if (start_acc) begin
            fetch_cnt <= '0;
         end else if (pop && (fetch_cnt != 16'hFFFF)) begin
            fetch_cnt <= fetch_cnt + 16'd1;
         end

         if (start_acc) begin
            err_oor <= 1'b0;
         end else if (spike_acc && spike_oor) begin
            err_oor <= 1'b1;
         end
      end
   end

   // row storage carries no reset; the pointers alone define what is valid
   always_ff @(posedge clk) begin
      if (rd_pend) begin
         fifo_data[wr_ptr] <= ram_rdata;
         fifo_last[wr_ptr] <= rd_pend_last;
      end
   end

   assign wout_valid = !fifo_empty;
   assign wout_data  = wout_valid ? fifo_data[rd_ptr] : '0;
   assign wout_last  = wout_valid ? fifo_last[rd_ptr] : 1'b0;

endmodule

// File: tb/tb_weight_fetch_ctrl.sv
// Scoreboard bench for weight_fetch_ctrl; DEEPTH=500 so out-of-range indices are reachable.
module tb_weight_fetch_ctrl;
   localparam int DEEPTH  = 500;
   localparam int ADDRWID = 9;
   localparam int P       = 64;
   localparam int WIDTH   = 8*P;
   localparam int FDEPTH  = 4;

   logic               clk = 1'b0;
   logic               rst_n = 1'b0;
   logic               start = 1'b0;
   logic               busy, done;
   logic               spike_valid = 1'b0;
   logic               spike_ready;
   logic [ADDRWID-1:0] spike_idx = '0;
   logic               spike_last = 1'b0;
   logic               ram_ren;
   logic [ADDRWID-1:0] ram_raddr;
   logic [WIDTH-1:0]   ram_rdata = '0;
   logic               wout_valid;
   logic               wout_ready = 1'b1;
   logic [WIDTH-1:0]   wout_data;
   logic               wout_last;
   logic [15:0]        fetch_cnt;
   logic               err_oor;
`ifdef WFC_BASE_EN
   logic [ADDRWID-1:0] layer_base = '0;
`endif

   int n_chk = 0;
   int n_pass = 0;
   int cyc = 0;
   logic [WIDTH:0] exp_q[$];
   int pop_cyc[$];

   always #5 clk = ~clk;

   weight_fetch_ctrl #(.DEEPTH(DEEPTH), .ADDRWID(ADDRWID), .P(P), .WIDTH(WIDTH), .FDEPTH(FDEPTH)) dut (
      .clk(clk), .rst_n(rst_n),
`ifdef WFC_BASE_EN
      .layer_base(layer_base),
`endif
      .start(start), .busy(busy), .done(done),
      .spike_valid(spike_valid), .spike_ready(spike_ready), .spike_idx(spike_idx), .spike_last(spike_last),
      .ram_ren(ram_ren), .ram_raddr(ram_raddr), .ram_rdata(ram_rdata),
      .wout_valid(wout_valid), .wout_ready(wout_ready), .wout_data(wout_data), .wout_last(wout_last),
      .fetch_cnt(fetch_cnt), .err_oor(err_oor)
   );

   // RAM model: row r holds byte r[7:0] in every lane; junk when not read
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (ram_ren) ram_rdata <= {P{ram_raddr[7:0]}};
      else         ram_rdata <= {16{$urandom()}};
   end

   function automatic logic [WIDTH-1:0] exp_row(input int idx);
      logic [WIDTH-1:0] r;
      logic [7:0] b;
      b = idx[7:0];
      for (int i = 0; i < P; i++) r[8*i +: 8] = b;
      return r;
   endfunction

   task automatic chk(input string nm, input logic [575:0] act, input logic [575:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
   endtask

   always @(negedge clk) begin
      if (rst_n && wout_valid && wout_ready) begin
         if (exp_q.size() == 0) begin
            n_chk++;
            $display("FAIL unexpected_row: got %0h with nothing expected", wout_data[63:0]);
         end else begin
            chk("row", {wout_last, wout_data}, exp_q.pop_front());
            pop_cyc.push_back(cyc);
         end
      end
   end

   task automatic send_spike(input int idx, input logic last, output int waited);
      logic in_rng;
      in_rng = (idx < DEEPTH);
      spike_valid = 1'b1;
      spike_idx   = idx[ADDRWID-1:0];
      spike_last  = last;
      waited      = 0;
      forever begin
         @(negedge clk);
         if (spike_ready) break;
         waited++;
         if (waited > 200) begin
            n_chk++;
            $display("FAIL spike_accept_timeout: idx %0d not accepted after %0d cycles", idx, waited);
            break;
         end
      end
      if (spike_ready) begin
         chk("ram_ren", ram_ren, in_rng);
         if (in_rng) begin
            chk("ram_raddr", ram_raddr, idx);
            exp_q.push_back({last, exp_row(idx)});
         end
      end
      @(posedge clk); #1;
   endtask

   task automatic idle_spike();
      spike_valid = 1'b0;
      spike_last  = 1'b0;
   endtask

   task automatic do_start();
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      chk("busy_after_start", busy, 1'b1);
   endtask

   task automatic wait_done();
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!done && n < 100);
      chk("done_seen", done, 1'b1);
      @(negedge clk);
      chk("done_one_cycle", done, 1'b0);
      chk("idle_after_done", busy, 1'b0);
      @(posedge clk); #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int w, wsum, gaps;
      logic [WIDTH-1:0] held;

      repeat (3) @(posedge clk);
      #1;
      chk("rst_outputs", {busy, done, spike_ready, ram_ren, wout_valid, wout_last, err_oor},  7'b0);
      chk("rst_values", {ram_raddr, wout_data, fetch_cnt}, '0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // single spike: accepted in N, row valid in N+2
      do_start();
      chk("fetch_cnt_clear", fetch_cnt, 16'd0);
      send_spike(5, 1'b1, w);
      idle_spike();
      @(negedge clk);
      chk("latency_n1", wout_valid, 1'b0);
      @(negedge clk);
      chk("latency_n2", wout_valid, 1'b1);
      @(posedge clk); #1;
      wait_done();
      chk("single_fetch_cnt", fetch_cnt, 16'd1);

      // burst of 8, wout_ready high
      do_start();
      pop_cyc.delete();
      wsum = 0;
      for (int i = 0; i < 8; i++) begin
         send_spike(i, (i == 7), w);
         wsum += w;
      end
      idle_spike();
      chk("burst_no_stall", wsum, 0);
      wait_done();
      chk("burst_rows", pop_cyc.size(), 8);
      gaps = 0;
      for (int i = 1; i < pop_cyc.size(); i++) if (pop_cyc[i] != pop_cyc[i-1] + 1) gaps++;
      chk("burst_1_per_cycle", gaps, 0);
      chk("burst_fetch_cnt", fetch_cnt, 16'd8);

      // backpressure: 6 offered, only FDEPTH accepted while stalled
      wout_ready = 1'b0;
      do_start();
      fork
         begin
            int wb;
            for (int i = 0; i < 6; i++) send_spike(10 + i, (i == 5), wb);
            idle_spike();
         end
         begin
            repeat (8) @(negedge clk);
            chk("bp_accepted", exp_q.size(), FDEPTH);
            chk("bp_ready_low", spike_ready, 1'b0);
            chk("bp_valid", wout_valid, 1'b1);
            held = wout_data;
            repeat (3) @(negedge clk);
            chk("bp_data_stable", wout_data, held);
            chk("bp_head_row", wout_data, exp_row(10));
            @(posedge clk); #1;
            wout_ready = 1'b1;
         end
      join
      wait_done();
      chk("bp_fetch_cnt", fetch_cnt, 16'd6);

      // simultaneous pop and accept at outstanding = FDEPTH-1
      wout_ready = 1'b0;
      do_start();
      for (int i = 0; i < 3; i++) send_spike(20 + i, 1'b0, w);
      idle_spike();
      @(posedge clk); #1;
      wout_ready = 1'b1;
      send_spike(23, 1'b0, w);
      chk("sim_accept_at_3", w, 0);
      wout_ready = 1'b0;
      send_spike(24, 1'b0, w);
      chk("sim_credit_kept", w, 0);
      spike_valid = 1'b1;
      spike_idx   = 9'd25;
      spike_last  = 1'b1;
      repeat (3) @(negedge clk);
      chk("sim_full", spike_ready, 1'b0);
      @(posedge clk); #1;
      wout_ready = 1'b1;
      send_spike(25, 1'b1, w);
      idle_spike();
      wait_done();
      chk("sim_fetch_cnt", fetch_cnt, 16'd6);

      // reset mid-frame with rows queued
      wout_ready = 1'b0;
      do_start();
      for (int i = 0; i < 3; i++) send_spike(30 + i, 1'b0, w);
      idle_spike();
      repeat (3) @(posedge clk);
      #1;
      chk("pre_rst_valid", wout_valid, 1'b1);
      rst_n = 1'b0;
      #1;
      chk("midrst_outputs", {busy, done, spike_ready, ram_ren, wout_valid, wout_last, err_oor}, 7'b0);
      chk("midrst_values", {ram_raddr, wout_data, fetch_cnt}, '0);
      exp_q.delete();
      @(posedge clk); #1;
      rst_n = 1'b1;
      wout_ready = 1'b1;
      @(posedge clk); #1;
      do_start();
      chk("post_rst_fetch_cnt0", fetch_cnt, 16'd0);
      send_spike(33, 1'b1, w);
      idle_spike();
      wait_done();
      chk("post_rst_fetch_cnt1", fetch_cnt, 16'd1);

      // start during RUN is ignored
      do_start();
      send_spike(40, 1'b0, w);
      idle_spike();
      repeat (4) @(posedge clk);
      #1;
      chk("run_fetch_cnt", fetch_cnt, 16'd1);
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      chk("start_ignored_cnt", fetch_cnt, 16'd1);
      chk("start_ignored_busy", busy, 1'b1);
      send_spike(41, 1'b1, w);
      idle_spike();
      wait_done();
      chk("ignored_fetch_cnt", fetch_cnt, 16'd2);

      // out-of-range last spike: no read, sticky error, frame completes
      do_start();
      chk("err_clear", err_oor, 1'b0);
      send_spike(3, 1'b0, w);
      send_spike(510, 1'b1, w);
      idle_spike();
      @(negedge clk);
      chk("err_oor_set", err_oor, 1'b1);
      wait_done();
      chk("oor_fetch_cnt", fetch_cnt, 16'd1);
      chk("err_oor_sticky", err_oor, 1'b1);
      do_start();
      chk("err_cleared_on_start", err_oor, 1'b0);
      send_spike(7, 1'b1, w);
      idle_spike();
      wait_done();

      chk("scoreboard_empty", exp_q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
